// File: rtl/matrix_ldst_fu.sv
`default_nettype none
// ============================================================================
// Module      : matrix_ldst_fu
// Description : Matrix load/store functional unit. Captures one issued LD/ST,
//               drives a held scratchpad request, then reports completion to
//               Issue and a load writeback to Dispatch. One op in flight.
//               Optional watchdog on WAIT/DRAIN: define MLS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_ldst_fu #(
    parameter int MAT_W          = 4,
    parameter int WORD_W         = 32,
    parameter int IMM_W          = 11,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              fu_en,
    input  logic              mem_type,
    input  logic [MAT_W-1:0]  rd,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic [IMM_W-1:0]  imm,
    input  logic              flush,
    output logic              busy,
    output logic              sp_req,
    input  logic              sp_ready,
    input  logic              sp_done,
    output logic [1:0]        ls_out,
    output logic [4:0]        rd_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] stride_out,
    output logic              done,
    output logic              wb_m_rw_en,
    output logic [MAT_W-1:0]  wb_m_rw,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_sp_req;
    logic [1:0]         r_ls;
    logic               r_done;
    logic               r_wb_en;
    logic [MAT_W-1:0]   r_wb_rw;
    logic               r_load;
    logic [MAT_W-1:0]   r_rd;
    logic [WORD_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_stride;
    logic [IMM_W-1:0]   r_imm;
    logic               w_expired;
    logic               w_wait_flush;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // A flush in WAIT that is not masked by a same-cycle completion moves to DRAIN.
    assign w_wait_flush = (r_state == S_WAIT) && flush && !sp_done;

`ifdef MLS_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout;
    logic               w_in_wait;

    assign w_in_wait = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign w_expired = w_in_wait && (r_cnt == c_CNT_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expired && !sp_done && !w_wait_flush;
            if (w_in_wait && !w_wait_flush) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_expired   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_sp_req <= 1'b0;
            r_ls     <= 2'b00;
            r_done   <= 1'b0;
            r_wb_en  <= 1'b0;
            r_wb_rw  <= '0;
            r_load   <= 1'b0;
            r_rd     <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_imm    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wb_en <= 1'b0;
            r_wb_rw <= '0;
            case (r_state)
                S_IDLE: begin
                    if (fu_en && !flush) begin
                        r_load   <= mem_type;
                        r_rd     <= rd;
                        r_addr   <= rdat1;
                        r_stride <= rdat2;
                        r_imm    <= imm;
                        r_busy   <= 1'b1;
                        r_sp_req <= 1'b1;
                        r_ls     <= mem_type ? 2'b10 : 2'b01;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An accepted request cannot be recalled, so the handshake beats flush.
                    if (sp_ready) begin
                        r_sp_req <= 1'b0;
                        r_ls     <= 2'b00;
                        r_state  <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        r_sp_req <= 1'b0;
                        r_ls     <= 2'b00;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (sp_done) begin
                        if (flush) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_done  <= 1'b1;
                            r_wb_en <= r_load;
                            r_wb_rw <= r_load ? r_rd : '0;
                            r_state <= S_DONE;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end else if (w_expired) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (sp_done || w_expired) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_sp_req <= 1'b0;
                    r_ls     <= 2'b00;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign sp_req     = r_sp_req;
    assign ls_out     = r_ls;
    assign rd_out     = 5'(r_rd);
    assign imm_out    = r_imm;
    assign address    = r_addr;
    assign stride_out = r_stride;
    assign done       = r_done;
    assign wb_m_rw_en = r_wb_en;
    assign wb_m_rw    = r_wb_rw;

endmodule
`default_nettype wire

// File: doc/matrix_ldst_fu.md
Name: matrix_ldst_fu

Overview:
- Matrix load/store functional unit; sits directly downstream of Issue, which asserts its FU enable, and upstream of the scratchpad.
- Captures one issued matrix LD/ST (base, stride, imm, destination matrix reg) and drives a held request with a valid/ready handshake.
- Waits for scratchpad completion, then pulses done to Issue and, for loads, the writeback matrix-register signals used by Dispatch to clear the RST.
- Single outstanding operation.

Parameters:
- MAT_W, 4, matrix register index width (16 matrix regs).
- WORD_W, 32, scalar data/address width.
- IMM_W, 11, immediate width.
- TIMEOUT_CYCLES, 256, watchdog limit (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- fu_en  in  1  issue strobe for this FU; honoured only when busy=0.
- mem_type  in  1  0=M_STORE, 1=M_LOAD.
- rd  in  MAT_W  destination/source matrix register.
- rdat1  in  WORD_W  base address (scalar rs1 value).
- rdat2  in  WORD_W  stride (scalar rs2 value).
- imm  in  IMM_W  immediate.
- flush  in  1  squash of the current operation.
- busy  out  1  FU occupied; Issue must not strobe fu_en.
- sp_req  out  1  request valid to scratchpad.
- sp_ready  in  1  scratchpad accepts the request.
- sp_done  in  1  scratchpad completion pulse.
- ls_out  out  2  {load,store} one-hot.
- rd_out  out  5  zero-extended rd.
- imm_out  out  IMM_W  captured imm.
- address  out  WORD_W  captured rdat1.
- stride_out  out  WORD_W  captured rdat2.
- done  out  1  one-cycle completion pulse to Issue.
- wb_m_rw_en  out  1  load writeback enable (pulse with done).
- wb_m_rw  out  MAT_W  load destination register.
- timeout_err  out  1  watchdog error pulse.

Behaviour:
- Reset: state=IDLE; all outputs and capture registers are 0.
- States:
  - IDLE: busy=0.
  - REQ: sp_req=1.
  - WAIT: waiting for sp_done.
  - DONE: done pulse.
  - DRAIN: squashed, waiting for sp_done.
- IDLE → REQ: on fu_en=1. Same edge captures mem_type, rd, rdat1, rdat2, imm; busy=1 from the next cycle.
- REQ:
  - sp_req=1; ls_out = 2'b10 for a load, 2'b01 for a store.
  - rd_out, imm_out, address and stride_out are driven from capture registers and held stable until the handshake.
  - sp_req && sp_ready → WAIT; sp_req drops the next cycle.
- WAIT: on sp_done → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - If a load, wb_m_rw_en=1 and wb_m_rw=rd; otherwise both are 0.
  - Next state is IDLE; busy=0 in that IDLE cycle.
- Minimum latency from fu_en to done: 3 cycles (ready and done each arriving the cycle after they are sampled as possible: REQ, WAIT, DONE).
- sp_done sampled in REQ is ignored (protocol violation; no state change).
- flush:
  - In REQ with sp_ready=0: → IDLE; no request is accepted; no done.
  - In REQ with sp_ready=1 the same cycle: the handshake wins; → DRAIN.
  - In WAIT: → DRAIN.
  - DRAIN: busy=1 until sp_done, then → IDLE with no done and no writeback.
  - In IDLE or DONE: ignored; the done pulse still occurs.
  - flush with fu_en in IDLE: the operation is not accepted.
- fu_en while busy=1: ignored; no capture.
- Reset mid-operation: immediate return to IDLE, outputs cleared; a later stray sp_done is ignored.
- ls_out is 2'b00 whenever sp_req=0.

Optional Feature:
- Macro MLS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT or DRAIN and increments each cycle there.
  - Reaching TIMEOUT_CYCLES-1 without sp_done: timeout_err pulses 1 cycle, state → IDLE, no done, no writeback.
  - sp_done in the same cycle as expiry wins: normal completion, no error.
- Not defined: no counter; timeout_err tied 0; WAIT/DRAIN persist indefinitely.

Test Plan:
- Load happy path: fu_en, mem_type=1, rd=4'hA, rdat1=32'h1000, rdat2=32'h40, imm=11'h7; sp_ready=1 at once; sp_done 2 cycles later → sp_req 1 cycle with ls_out=2'b10, rd_out=5'h0A, address=32'h1000, stride_out=32'h40; done and wb_m_rw_en pulse once with wb_m_rw=4'hA; busy=0 after.
- Store with backpressure: mem_type=0, sp_ready low for 5 cycles → sp_req and all fields held stable 6 cycles, ls_out=2'b01; done pulses with wb_m_rw_en=0.
- Busy rejection: second fu_en with rd=4'h3 while in WAIT → ignored; wb_m_rw stays 4'hA for the first op.
- Flush: flush in REQ with sp_ready=0 → IDLE next cycle, no done. Flush in WAIT → busy held until sp_done, then no done and no writeback.
- Reset mid-WAIT: nRST low → all outputs 0 asynchronously; sp_done afterwards produces no done.
- MLS_TIMEOUT_EN with TIMEOUT_CYCLES=16: no sp_done → timeout_err pulses once 16 cycles after entering WAIT, busy→0. Separately, sp_done on the expiry cycle → done=1, timeout_err=0.
